// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch slice: state encoding and
// PC stepping / alignment constants.
package inst_fetch_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    localparam int unsigned PC_STEP    = 4;
    localparam int unsigned ALIGN_BITS = 2;

endpackage : inst_fetch_pkg

// File: rtl/inst_fetch_fifo.sv
// Synchronous FIFO of packed {pc, inst} fetch entries; flush beats push/pop.
// Head reads as zero while the buffer is empty.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                mem[wptr] <= din;
                wptr      <= wptr + AW'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : fetch_fifo

// File: rtl/inst_fetch.sv
// Fetch initiator: PC register, RUN/FAULT state machine and the push/pop
// control around a small {pc, inst} buffer feeding decode.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned                  PC_WIDTH_LENGTH   = 32,
    parameter int unsigned                  INST_WIDTH_LENGTH = 32,
    parameter logic [PC_WIDTH_LENGTH-1:0]   RESET_PC          = 32'h0000_0000,
    parameter int unsigned                  FIFO_DEPTH        = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [PC_WIDTH_LENGTH-1:0]   imem_pc,
    input  logic [INST_WIDTH_LENGTH-1:0] imem_inst,
    input  logic                         redirect_valid,
    input  logic [PC_WIDTH_LENGTH-1:0]   redirect_pc,
    output logic                         out_valid,
    output logic [INST_WIDTH_LENGTH-1:0] out_inst,
    output logic [PC_WIDTH_LENGTH-1:0]   out_pc,
    input  logic                         out_ready,
    output logic                         fetch_fault
);

    localparam int unsigned EW = PC_WIDTH_LENGTH + INST_WIDTH_LENGTH;

    fetch_state_t                 state_q;
    fetch_state_t                 state_d;
    logic [PC_WIDTH_LENGTH-1:0]   pc_q;
    logic [PC_WIDTH_LENGTH-1:0]   pc_d;
    logic                         fetch_en;
    logic                         pop;
    logic                         full;
    logic                         empty;
    logic [EW-1:0]                dout;

    assign imem_pc     = pc_q;
    assign fetch_fault = (state_q == FAULT);
    assign out_valid   = !empty;
    assign out_pc      = dout[EW-1:INST_WIDTH_LENGTH];
    assign out_inst    = dout[INST_WIDTH_LENGTH-1:0];

    // A full buffer blocks the push even if decode pops the same cycle.
    assign fetch_en = (state_q == RUN) && !redirect_valid && !full;
    assign pop      = out_valid && out_ready && !redirect_valid;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            state_d = (redirect_pc[ALIGN_BITS-1:0] == '0) ? RUN : FAULT;
        end else if (fetch_en) begin
            pc_d = pc_q + PC_WIDTH_LENGTH'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (fetch_en),
        .pop   (pop),
        .din   ({pc_q, imem_inst}),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

endmodule : inst_fetch
